// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the serial shift controller: FSM state encoding
// and default word width / bit-period constants.
package shift_ctrl_pkg;

    localparam int DEFAULT_N   = 8;
    localparam int DEFAULT_DIV = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/piso_shifter.sv
// Generic N-bit shift register: parallel load, shift right with the serial
// input entering at the MSB, serial output taken from bit 0, parallel output.
// Used once for the transmit word and once for the receive word.
module piso_shifter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [N-1:0] load_data,
    input  logic         shift_en,
    input  logic         s_in,
    output logic         s_out,
    output logic [N-1:0] q
);

    // Load has priority over shift; a shift moves every bit one place toward bit 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift_en) begin
            q <= {s_in, q[N-1:1]};
        end
    end

    assign s_out = q[0];

endmodule

// File: rtl/shift_controller.sv
// Full-duplex serial word transfer controller. A word accepted on the
// tx_valid/tx_ready handshake is shifted out LSB first on s_out while s_in is
// sampled on each sclk rising edge; the received word is published on
// rx_data with a one-cycle rx_valid pulse when the transfer completes.
module shift_controller
    import shift_ctrl_pkg::*;
#(
    parameter int N   = DEFAULT_N,
    parameter int DIV = DEFAULT_DIV
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] tx_data,
    input  logic         tx_valid,
    output logic         tx_ready,
    output logic         s_out,
    input  logic         s_in,
    output logic         sclk,
    output logic         busy,
    output logic [N-1:0] rx_data,
    output logic         rx_valid,
    output logic [1:0]   dbg_state
);

    localparam int DIV_W = $clog2(DIV);
    localparam int BIT_W = $clog2(N);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF   = DIV_W'(DIV / 2);
    localparam logic [DIV_W-1:0] DIV_SAMPLE = DIV_W'(DIV / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(N - 1);

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;

    logic             handshake;
    logic             div_wrap;
    logic             last_bit;
    logic             sample;

    logic             tx_lsb;
    logic [N-1:0]     rx_word;
    logic [N-1:0]     unused_tx_word;
    logic             unused_rx_lsb;

    // Handshake: a word is transferred on a posedge where tx_valid and
    // tx_ready are both high. tx_valid may be held by the requester at any
    // time; it has no effect while tx_ready is low, and tx_data is captured
    // only on the handshake edge.
    assign handshake = (state == IDLE) && tx_valid && tx_ready;

    // End of a bit period, last bit period, and the sclk-rising sample point.
    assign div_wrap  = (state == SHIFT) && (div_cnt == DIV_LAST);
    assign last_bit  = div_wrap && (bit_cnt == BIT_LAST);
    assign sample    = (state == SHIFT) && (div_cnt == DIV_SAMPLE);

    // Serial clock: low for the first half of each bit period, high for the second.
    assign sclk      = (state == SHIFT) && (div_cnt >= DIV_HALF);

    // The TX register shifts at each bit boundary, so bit 0 is always the
    // current bit; outside SHIFT the line is held low.
    assign s_out     = (state == SHIFT) ? tx_lsb : 1'b0;

    assign dbg_state = state;

    // Control FSM with divider and bit counters; handshake outputs are registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (handshake) begin
                        state    <= SHIFT;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                        tx_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (div_wrap) begin
                        div_cnt <= '0;
                        if (last_bit) begin
                            // All N samples are already in the RX register here.
                            state    <= DONE;
                            bit_cnt  <= '0;
                            rx_data  <= rx_word;
                            rx_valid <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    tx_ready <= 1'b1;
                    busy     <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    div_cnt  <= '0;
                    bit_cnt  <= '0;
                    tx_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    // Transmit word: loaded on handshake, shifted out toward bit 0 once per bit period.
    piso_shifter #(.N(N)) u_tx_shifter (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (handshake),
        .load_data (tx_data),
        .shift_en  (div_wrap),
        .s_in      (1'b0),
        .s_out     (tx_lsb),
        .q         (unused_tx_word)
    );

    // Receive word: cleared on handshake, s_in enters at the MSB on each sclk
    // rise so that after N samples the first bit received sits at bit 0.
    piso_shifter #(.N(N)) u_rx_shifter (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (handshake),
        .load_data ({N{1'b0}}),
        .shift_en  (sample),
        .s_in      (s_in),
        .s_out     (unused_rx_lsb),
        .q         (rx_word)
    );

endmodule

// File: doc/shift_controller.md
SHIFT_CONTROLLER -- requirements
Module: shift_controller

Interface
REQ-001 Parameter N, default 8: word width in bits (N >= 2).
REQ-002 Parameter DIV, default 4: clk cycles per serial bit (even, >= 2).
REQ-003 clk  input  1  sole clock; all state changes on posedge clk.
REQ-004 reset_n  input  1  asynchronous reset, active-low.
REQ-005 tx_data  input  N  parallel word to transmit.
REQ-006 tx_valid  input  1  tx_data is valid.
REQ-007 tx_ready  output  1  controller is ready to accept a word.
REQ-008 s_out  output  1  serial data out, LSB first.
REQ-009 s_in  input  1  serial data in, LSB first.
REQ-010 sclk  output  1  serial bit clock.
REQ-011 busy  output  1  high while a transfer is in progress.
REQ-012 rx_data  output  N  word received on s_in during the last transfer.
REQ-013 rx_valid  output  1  one-cycle pulse; rx_data is updated.

Function
REQ-014 FSM states SHALL be IDLE, SHIFT and DONE.
- IDLE -> SHIFT on tx_valid && tx_ready.
- SHIFT -> DONE after N bit periods.
- DONE -> IDLE unconditionally after one cycle.
REQ-015 tx_ready SHALL be 1 only in IDLE.
REQ-016 A handshake SHALL parallel-load tx_data into the TX shift register; tx_data changes after the handshake SHALL have no effect.
REQ-017 In SHIFT, a divider counter div_cnt SHALL count 0..DIV-1, with a bit counter bit_cnt of 0..N-1 advancing when div_cnt wraps.
REQ-018 sclk SHALL be 1 when state==SHIFT && div_cnt >= DIV/2, and 0 otherwise.
REQ-019 s_out SHALL present TX bit bit_cnt (LSB first) for the whole bit period; the TX register SHALL shift right by one at each div_cnt wrap.
REQ-020 In IDLE and DONE, s_out SHALL be 0.
REQ-021 s_in SHALL be sampled on the edge where div_cnt goes DIV/2-1 -> DIV/2 (sclk rising), shifted into the MSB of the RX register, which shifts right.
REQ-022 After N samples, the first received bit SHALL be at rx_data[0].
REQ-023 On entry to DONE, rx_data SHALL be loaded from the RX register and rx_valid SHALL be 1 for exactly that cycle.
REQ-024 rx_data SHALL hold its value until the next DONE.
REQ-025 busy SHALL be 1 in SHIFT and DONE.
REQ-026 Cycle timing, with the handshake at edge 0:
- SHIFT occupies cycles 1..N*DIV.
- DONE occupies cycle N*DIV+1.
- tx_ready SHALL be 1 again at cycle N*DIV+2.
REQ-027 tx_valid asserted during SHIFT or DONE SHALL be ignored and SHALL not be lost from the requester's view (the requester holds it until tx_ready).
REQ-028 Back-to-back transfers: with tx_valid held high, a new handshake SHALL occur in the first IDLE cycle, giving a period of N*DIV+2 cycles.
REQ-029 Counters SHALL use $clog2 widths and SHALL never exceed DIV-1 or N-1.

Reset
REQ-030 reset_n low SHALL immediately force:
- state=IDLE, div_cnt=0, bit_cnt=0;
- TX and RX registers to 0;
- rx_data=0, rx_valid=0, busy=0, sclk=0, s_out=0;
- tx_ready=1 after release.
REQ-031 Reset asserted mid-transfer SHALL abort the transfer with no rx_valid pulse, and the aborted word SHALL not be resumed.
REQ-032 The first handshake SHALL be possible on the first posedge clk after reset_n deasserts.

Structure
REQ-033 A shared package shift_ctrl_pkg SHALL hold the state enum typedef (IDLE, SHIFT, DONE) and the default N/DIV constants.
REQ-034 One sub-module piso_shifter (parameter N; parallel load, shift-right enable, serial in at MSB, serial out at bit 0, parallel out) SHALL be instantiated twice, once for TX and once for RX.
REQ-035 All FSM, divider and counter logic SHALL reside in shift_controller.

Verification (N=8, DIV=4)
REQ-036 Single transfer:
- Stimulus: tx_data=8'hA5, tx_valid for 1 cycle, s_in looped to s_out.
- Response: s_out sequence 1,0,1,0,0,1,0,1, each bit 4 cycles; 8 sclk pulses; rx_valid at cycle 33 with rx_data=8'hA5; tx_ready at cycle 34.
REQ-037 Independent RX:
- Stimulus: s_in driven with 8'h3C, LSB first, stable around each sclk rise; tx_data=8'hFF.
- Response: rx_data=8'h3C.
REQ-038 Back-to-back:
- Stimulus: tx_valid held high with 8'h01, then 8'h80.
- Response: second handshake exactly 34 cycles after the first; no gap or overlap in busy beyond the 1-cycle IDLE.
REQ-039 Busy-time request:
- Stimulus: tx_data changed to 8'h00 during SHIFT.
- Response: the transmitted word is unchanged, and tx_ready stays 0 until IDLE.
REQ-040 Reset mid-transfer:
- Stimulus: reset_n pulled low at cycle 15.
- Response: all outputs immediately take their reset values; no rx_valid; a subsequent transfer of 8'h5A completes correctly.
